// File: rtl/trace_drain_pkg.sv
// Trace ring CSR window map, STATUS field positions and CTRL bit positions shared with the ring.
package trace_drain_pkg;

  localparam int CSR_ADDR_W = 16;

  localparam logic [CSR_ADDR_W-1:0] CARBON_CSR_TRACE_CTL    = 16'h0140;
  localparam logic [CSR_ADDR_W-1:0] CARBON_CSR_TRACE_STATUS = CARBON_CSR_TRACE_CTL + 16'd1;
  localparam logic [CSR_ADDR_W-1:0] CARBON_CSR_TRACE_DATA0  = CARBON_CSR_TRACE_CTL + 16'd4;

  localparam int TRACE_STATUS_NEMPTY_BIT = 0;
  localparam int TRACE_STATUS_FULL_BIT   = 1;
  localparam int TRACE_STATUS_CNT_LSB    = 8;

  typedef enum int unsigned {
    TRACE_CTRL_EN_BIT  = 0,
    TRACE_CTRL_CLR_BIT = 1
  } trace_ctrl_bit_e;

  function automatic logic [31:0] trace_ctrl_word(input logic en, input logic clr);
    logic [31:0] w;
    w = '0;
    w[int'(TRACE_CTRL_EN_BIT)]  = en;
    w[int'(TRACE_CTRL_CLR_BIT)] = clr;
    return w;
  endfunction

endpackage

// File: rtl/csr_if.sv
// Single-outstanding CSR bus: request channel and response channel, each valid/ready.
interface csr_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              rsp_side_effect;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
  );
endinterface

// File: rtl/trace_drain.sv
// Drains the trace ring over CSR (enable, poll STATUS, read DATA0..3) and emits whole records; one CSR op in flight.
// Start to first CTRL request is one cycle; EMIT holds out_valid/out_data with no CSR traffic until out_ready.
module trace_drain
  import trace_drain_pkg::*;
#(
  parameter int REC_W      = 128,
  parameter int CSR_DATA_W = 32,
  parameter int CNT_W      = 5,
  parameter int POLL_GAP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  csr_if.master            csr,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_on_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic             busy,
  output logic             err,
  output logic [31:0]      rec_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_EN_REQ   = 4'd1;
  localparam logic [3:0] S_EN_RSP   = 4'd2;
  localparam logic [3:0] S_POLL_REQ = 4'd3;
  localparam logic [3:0] S_POLL_RSP = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_RD_REQ   = 4'd6;
  localparam logic [3:0] S_RD_RSP   = 4'd7;
  localparam logic [3:0] S_EMIT     = 4'd8;
  localparam logic [3:0] S_DIS_REQ  = 4'd9;
  localparam logic [3:0] S_DIS_RSP  = 4'd10;
  localparam logic [3:0] S_ERR      = 4'd11;

  localparam int              GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  logic [3:0]            state_q, state_d;
  logic                  req_valid_q, req_write_q, rsp_ready_q;
  logic [CSR_ADDR_W-1:0] req_addr_q;
  logic [CSR_DATA_W-1:0] req_wdata_q;
  logic [1:0]            w_q, w_d;
  logic [CNT_W-1:0]      pend_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  stop_q, err_q;
  logic [31:0]           rec_count_q;
  logic [127:0]          rec_q;

  logic             req_fire, rsp_fire, out_fire, stop_pend;
  logic             idle_start, launch, rd_ok;
  logic [CNT_W-1:0] status_cnt;

  assign req_fire   = req_valid_q && csr.req_ready;
  assign rsp_fire   = rsp_ready_q && csr.rsp_valid;
  assign out_fire   = (state_q == S_EMIT) && out_ready;
  assign stop_pend  = stop_q || stop;
  assign idle_start = ((state_q == S_IDLE) || (state_q == S_ERR)) && start;
  assign rd_ok      = (state_q == S_RD_RSP) && rsp_fire && !csr.rsp_fault;
  assign status_cnt = csr.rsp_rdata[TRACE_STATUS_CNT_LSB +: CNT_W];

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE, S_ERR: if (start) begin
        state_d = S_EN_REQ;
        w_d     = 2'd0;
      end
      S_EN_REQ:   if (req_fire) state_d = S_EN_RSP;
      S_EN_RSP:   if (rsp_fire) state_d = csr.rsp_fault ? S_ERR : S_POLL_REQ;
      S_POLL_REQ: if (req_fire) state_d = S_POLL_RSP;
      S_POLL_RSP: if (rsp_fire) begin
        if (csr.rsp_fault)          state_d = S_ERR;
        else if (stop_pend)         state_d = S_DIS_REQ;
        else if (status_cnt == '0)  state_d = S_GAP;
        else                        state_d = S_RD_REQ;
      end
      S_GAP: begin
        if (stop_pend)          state_d = S_DIS_REQ;
        else if (gap_q == '0)   state_d = S_POLL_REQ;
      end
      S_RD_REQ:   if (req_fire) state_d = S_RD_RSP;
      S_RD_RSP: if (rsp_fire) begin
        // A faulted DATA0 read is an empty-ring underflow, not a protocol error.
        if (csr.rsp_fault)     state_d = (w_q == 2'd0) ? S_POLL_REQ : S_ERR;
        else begin
          w_d     = w_q + 2'd1;
          state_d = (w_q == 2'd3) ? S_EMIT : S_RD_REQ;
        end
      end
      S_EMIT: if (out_ready) begin
        if (stop_pend)                   state_d = S_DIS_REQ;
        else if (pend_q > CNT_W'(1))     state_d = S_RD_REQ;
        else                             state_d = S_POLL_REQ;
      end
      S_DIS_REQ:  if (req_fire) state_d = S_DIS_RSP;
      S_DIS_RSP:  if (rsp_fire) state_d = csr.rsp_fault ? S_ERR : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign launch = (state_d != state_q) &&
                  (state_d inside {S_EN_REQ, S_POLL_REQ, S_RD_REQ, S_DIS_REQ});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rsp_ready_q <= 1'b0;
      w_q         <= '0;
      pend_q      <= '0;
      gap_q       <= '0;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      rec_count_q <= '0;
      rec_q       <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      rsp_ready_q <= state_d inside {S_EN_RSP, S_POLL_RSP, S_RD_RSP, S_DIS_RSP};

      if (launch) begin
        req_valid_q <= 1'b1;
        case (state_d)
          S_EN_REQ: begin
            req_addr_q  <= CARBON_CSR_TRACE_CTL;
            req_write_q <= 1'b1;
            req_wdata_q <= CSR_DATA_W'(trace_ctrl_word(1'b1, clear_on_start));
          end
          S_DIS_REQ: begin
            req_addr_q  <= CARBON_CSR_TRACE_CTL;
            req_write_q <= 1'b1;
            req_wdata_q <= '0;
          end
          S_POLL_REQ: begin
            req_addr_q  <= CARBON_CSR_TRACE_STATUS;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
          end
          default: begin
            req_addr_q  <= CARBON_CSR_TRACE_DATA0 + CSR_ADDR_W'(w_d);
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
          end
        endcase
      end else if (req_fire) begin
        req_valid_q <= 1'b0;
      end

      // A start+stop in the same cycle keeps the stop, so the block enables, polls once and disables.
      if (idle_start) begin
        stop_q <= stop;
        err_q  <= 1'b0;
      end else if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
        stop_q <= 1'b0;
      end else if (stop) begin
        stop_q <= 1'b1;
      end

      if ((state_d == S_ERR) && (state_q != S_ERR)) err_q <= 1'b1;

      if ((state_q == S_POLL_RSP) && rsp_fire && !csr.rsp_fault) pend_q <= status_cnt;
      else if (out_fire)                                       pend_q <= pend_q - CNT_W'(1);

      if ((state_d == S_GAP) && (state_q != S_GAP))  gap_q <= GAP_LOAD;
      else if ((state_q == S_GAP) && (gap_q != '0))  gap_q <= gap_q - GAP_W'(1);

      if (rd_ok)    rec_q[{w_q, 5'b0} +: 32] <= csr.rsp_rdata;
      if (out_fire) rec_count_q <= rec_count_q + 32'd1;
    end
  end

  assign csr.req_valid = req_valid_q;
  assign csr.req_addr  = req_addr_q;
  assign csr.req_write = req_write_q;
  assign csr.req_wdata = req_wdata_q;
  assign csr.rsp_ready = rsp_ready_q;

  assign out_valid = (state_q == S_EMIT);
  assign out_data  = rec_q[REC_W-1:0];
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign rec_count = rec_count_q;

  logic unused_side_effect;
  assign unused_side_effect = &{1'b0, csr.rsp_side_effect};

endmodule

// File: tb/tb_trace_drain.sv
// Bench for trace_drain: behavioural trace ring behind the CSR port plus a record scoreboard on the output stream.
module tb_trace_drain;
  import trace_drain_pkg::*;

  localparam int POLL_GAP = 16;
  localparam logic [15:0] A_CTL = CARBON_CSR_TRACE_CTL;
  localparam logic [15:0] A_ST  = CARBON_CSR_TRACE_STATUS;
  localparam logic [15:0] A_D0  = CARBON_CSR_TRACE_DATA0;

  localparam logic [127:0] REC_A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_00000001;
  localparam logic [127:0] REC_B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_00000002;
  localparam logic [127:0] REC_C = 128'hC0FFEE03_C0FFEE02_C0FFEE01_C0FFEE00;
  localparam logic [127:0] REC_D = 128'h0D0D0D03_0D0D0D02_0D0D0D01_0D0D0D00;
  localparam logic [127:0] REC_E = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
  localparam logic [127:0] REC_F = 128'hF00F0003_F00F0002_F00F0001_F00F0000;
  localparam logic [127:0] REC_G = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, clear_on_start, out_ready;
  logic         out_valid, busy, err;
  logic [127:0] out_data;
  logic [31:0]  rec_count;

  csr_if #(.ADDR_W(CSR_ADDR_W), .DATA_W(32)) csr ();

  trace_drain #(.REC_W(128), .CSR_DATA_W(32), .CNT_W(5), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .csr(csr), .start(start), .stop(stop),
    .clear_on_start(clear_on_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .err(err), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_recs = 0;
  logic [127:0] ring_q[$];
  logic [127:0] exp_q[$];
  txn_t         csr_log[$];
  bit           fault_arm = 1'b0;
  int           fault_off = 0;

  // Trace ring model: accepts at once, answers the cycle after, DATA3 read pops the head record.
  initial begin : responder
    logic         rf, qf, w;
    logic [15:0]  a;
    logic [31:0]  d;
    logic [127:0] rec;
    int           off;
    csr.req_ready = 1'b1;
    csr.rsp_valid = 1'b0;
    csr.rsp_rdata = '0;
    csr.rsp_fault = 1'b0;
    csr.rsp_side_effect = 1'b0;
    forever begin
      @(negedge clk); #1;
      rf = csr.req_valid && csr.req_ready && rst_n;
      qf = csr.rsp_valid && csr.rsp_ready;
      a = csr.req_addr; w = csr.req_write; d = csr.req_wdata;
      @(posedge clk); #1;
      if (qf) begin
        csr.rsp_valid = 1'b0; csr.rsp_fault = 1'b0; csr.rsp_rdata = '0; csr.rsp_side_effect = 1'b0;
      end
      if (rf) begin
        csr_log.push_back('{addr: a, wr: w, wdata: d});
        off = int'(a) - int'(A_CTL);
        csr.rsp_valid = 1'b1; csr.rsp_fault = 1'b0; csr.rsp_rdata = '0; csr.rsp_side_effect = 1'b0;
        if (fault_arm && off == fault_off) begin
          csr.rsp_fault = 1'b1;
          fault_arm = 1'b0;
        end else if (off == 0 && w) begin
          if (d[1]) ring_q.delete();
        end else if (off == 1) begin
          csr.rsp_rdata = (32'(ring_q.size()) << 8) |
                          {30'd0, (ring_q.size() >= 16), (ring_q.size() != 0)};
        end else if (off >= 4 && off <= 7) begin
          if (ring_q.size() == 0) csr.rsp_fault = 1'b1;
          else begin
            rec = ring_q[0];
            csr.rsp_rdata = rec[32*(off-4) +: 32];
            if (off == 7) begin
              csr.rsp_side_effect = 1'b1;
              void'(ring_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : out_scoreboard
    logic [127:0] exp;
    forever begin
      @(negedge clk); #1;
      if (rst_n && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %h, no record was queued", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            n_fail++;
            $display("FAIL out_data: got %h expected %h", out_data, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic clr, input logic stp);
    start = 1'b1; clear_on_start = clr; stop = stp;
    @(negedge clk);
    start = 1'b0; clear_on_start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_stop(output int cyc);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_checks++; if (rec_count !== 32'd0) begin n_fail++; $display("FAIL rst_rec_count: got %0d expected 0", rec_count); end
    n_checks++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_checks++; if (csr.req_valid !== 1'b0 || csr.rsp_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_csr: got req_valid=%b rsp_ready=%b expected 0/0", csr.req_valid, csr.rsp_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || csr.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst: got busy=%b req_valid=%b expected 0/0", busy, csr.req_valid);
    end
  endtask

  task automatic test_two_records();
    bit ok;
    int cyc;
    csr_log.delete();
    ring_q.push_back(REC_A); ring_q.push_back(REC_B);
    exp_q.push_back(REC_A);  exp_q.push_back(REC_B);
    exp_recs += 2;
    pulse_start(1'b0, 1'b0);
    n_checks++;
    if (!(csr.req_valid === 1'b1 && csr.req_addr === A_CTL && csr.req_write === 1'b1 && csr.req_wdata === 32'h1)) begin
      n_fail++; $display("FAIL start_ctrl_req: got valid=%b addr=%h wr=%b wdata=%h expected 1/%h/1/00000001",
                         csr.req_valid, csr.req_addr, csr.req_write, csr.req_wdata, A_CTL);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL two_rec_drain: got %0d records left expected 0", exp_q.size()); end
    n_checks++; if (rec_count !== 32'(exp_recs)) begin n_fail++; $display("FAIL two_rec_count: got %0d expected %0d", rec_count, exp_recs); end
    do_stop(cyc);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_rec_stop: got busy=%b expected 0", busy); end
    ok = (csr_log.size() >= 11);
    if (ok) begin
      if (csr_log[1].addr !== A_ST || csr_log[1].wr !== 1'b0) ok = 1'b0;
      for (int i = 2; i < 10; i++)
        if (csr_log[i].addr !== A_D0 + 16'((i - 2) % 4) || csr_log[i].wr !== 1'b0) ok = 1'b0;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL two_rec_seq: got %0d txns, order wrong; expected STATUS then DATA0..3 x2", csr_log.size()); end
    n_checks++;
    if (csr_log.size() == 0 || csr_log[$].addr !== A_CTL || csr_log[$].wr !== 1'b1 || csr_log[$].wdata !== 32'h0) begin
      n_fail++; $display("FAIL two_rec_disable: got last txn not CTRL write 0 (log size %0d)", csr_log.size());
    end
  endtask

  task automatic test_poll_gap();
    int idle, cyc, ndata;
    csr_log.delete();
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 50 && !(csr.req_valid && csr.req_addr == A_ST); i++) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      idle = 0;
      @(negedge clk);
      for (int i = 0; i < 200 && !csr.req_valid; i++) begin
        if (!csr.rsp_valid) idle++;
        @(negedge clk);
      end
      n_checks++;
      if (csr.req_valid !== 1'b1 || csr.req_addr !== A_ST || idle != POLL_GAP) begin
        n_fail++; $display("FAIL poll_gap%0d: got idle=%0d addr=%h valid=%b expected idle=%0d addr=%h", g, idle, csr.req_addr, csr.req_valid, POLL_GAP, A_ST);
      end
    end
    do_stop(cyc);
    ndata = 0;
    foreach (csr_log[i]) if (csr_log[i].addr >= A_D0 && csr_log[i].addr <= A_D0 + 16'd3) ndata++;
    n_checks++; if (ndata != 0) begin n_fail++; $display("FAIL poll_no_data: got %0d DATA reads expected 0", ndata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL poll_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int bad, cyc;
    out_ready = 1'b0;
    ring_q.push_back(REC_C); exp_q.push_back(REC_C); exp_recs++;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== REC_C || csr.req_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_release: got %0d records left expected 0", exp_q.size()); end
    n_checks++; if (rec_count !== 32'(exp_recs)) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", rec_count, exp_recs); end
    do_stop(cyc);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_underflow();
    int nd0, cyc;
    csr_log.delete();
    ring_q.push_back(REC_D); exp_q.push_back(REC_D); exp_recs++;
    fault_off = 4; fault_arm = 1'b1;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL uflow_drain: got %0d records left expected 0", exp_q.size()); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL uflow_err: got %b expected 0", err); end
    nd0 = 0;
    foreach (csr_log[i]) if (csr_log[i].addr == A_D0) nd0++;
    n_checks++; if (nd0 != 2) begin n_fail++; $display("FAIL uflow_retry: got %0d DATA0 reads expected 2", nd0); end
    do_stop(cyc);
    n_checks++; if (busy !== 1'b0 || rec_count !== 32'(exp_recs)) begin
      n_fail++; $display("FAIL uflow_end: got busy=%b count=%0d expected 0/%0d", busy, rec_count, exp_recs);
    end
  endtask

  task automatic test_fault();
    int reqs, cyc;
    ring_q.push_back(REC_E);
    fault_off = 6; fault_arm = 1'b1;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 100 && !err; i++) @(negedge clk);
    n_checks++; if (err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL fault_err: got err=%b busy=%b expected 1/1", err, busy); end
    reqs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (csr.req_valid !== 1'b0 || out_valid !== 1'b0) reqs++;
    end
    n_checks++; if (reqs != 0) begin n_fail++; $display("FAIL fault_quiet: got %0d active cycles expected 0", reqs); end
    pulse_start(1'b1, 1'b0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_restart_err: got %b expected 0", err); end
    n_checks++;
    if (csr.req_valid !== 1'b1 || csr.req_addr !== A_CTL || csr.req_write !== 1'b1 || csr.req_wdata !== 32'h3) begin
      n_fail++; $display("FAIL clear_ctrl_req: got valid=%b addr=%h wr=%b wdata=%h expected 1/%h/1/00000003",
                         csr.req_valid, csr.req_addr, csr.req_write, csr.req_wdata, A_CTL);
    end
    repeat (6) @(negedge clk);
    do_stop(cyc);
    n_checks++; if (busy !== 1'b0 || rec_count !== 32'(exp_recs)) begin
      n_fail++; $display("FAIL fault_end: got busy=%b count=%0d expected 0/%0d", busy, rec_count, exp_recs);
    end
  endtask

  task automatic test_stop_mid_record();
    int nd;
    csr_log.delete();
    ring_q.push_back(REC_F); ring_q.push_back(REC_G);
    exp_q.push_back(REC_F); exp_recs++;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 100 && !(csr.req_valid && csr.req_addr == A_D0 + 16'd1); i++) @(negedge clk);
    n_checks++; if (csr.req_valid !== 1'b1 || csr.req_addr !== A_D0 + 16'd1) begin
      n_fail++; $display("FAIL stop_find_d1: got valid=%b addr=%h expected 1/%h", csr.req_valid, csr.req_addr, A_D0 + 16'd1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
    n_checks++; if (exp_q.size() != 0 || rec_count !== 32'(exp_recs)) begin
      n_fail++; $display("FAIL stop_emit: got left=%0d count=%0d expected 0/%0d", exp_q.size(), rec_count, exp_recs);
    end
    nd = 0;
    foreach (csr_log[i]) if (csr_log[i].addr >= A_D0 && csr_log[i].addr <= A_D0 + 16'd3) nd++;
    n_checks++; if (nd != 4) begin n_fail++; $display("FAIL stop_reads: got %0d DATA reads expected 4", nd); end
    n_checks++;
    if (csr_log.size() == 0 || csr_log[$].addr !== A_CTL || csr_log[$].wr !== 1'b1 || csr_log[$].wdata !== 32'h0) begin
      n_fail++; $display("FAIL stop_disable: got last txn not CTRL write 0 (log size %0d)", csr_log.size());
    end
    ring_q.delete();
  endtask

  task automatic test_start_stop_same();
    bit ok;
    csr_log.delete();
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy: got %b expected 0", busy); end
    ok = (csr_log.size() == 3);
    if (ok) ok = (csr_log[0].addr == A_CTL && csr_log[0].wdata == 32'h1 && csr_log[1].addr == A_ST &&
                  csr_log[2].addr == A_CTL && csr_log[2].wr && csr_log[2].wdata == 32'h0);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ss_seq: got %0d txns expected CTRL=1, STATUS, CTRL=0", csr_log.size()); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear_on_start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_two_records();
    test_poll_gap();
    test_backpressure();
    test_underflow();
    test_fault();
    test_stop_mid_record();
    test_start_stop_same();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
